// File: rtl/tmp101_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmp101_pkg
// Brief    : Shared state encoding and TMP101 constants for the sample collector.
// Revision : 1.0 - initial release
// ============================================================================
package tmp101_pkg;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_START   = 3'd1,
    ST_MSB     = 3'd2,
    ST_LSB     = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  localparam logic [7:0] TMP101_READ_ADDR = 8'b10010011;
  localparam int         RAW_WIDTH        = 12;
  localparam int         FRAC_BITS        = 4;

endpackage : tmp101_pkg
`default_nettype wire

// File: rtl/tmp101_code_to_decimal.sv
`default_nettype none
// ============================================================================
// Module   : tmp101_code_to_decimal
// Brief    : Combinational TMP101 12-bit code -> sign / degrees / tenths.
// Revision : 1.0 - initial release
// ============================================================================
module tmp101_code_to_decimal
  import tmp101_pkg::*;
(
  input  logic [RAW_WIDTH-1:0] raw,
  output logic                 sign,
  output logic [7:0]           degrees,
  output logic [3:0]           tenths
);

  logic [RAW_WIDTH-1:0] w_mag;
  logic [7:0]           w_frac_x10;

  assign sign    = raw[RAW_WIDTH-1];
  // 0x800 has no positive counterpart; it wraps to itself and reads as 128.
  assign w_mag   = sign ? (~raw + 1'b1) : raw;
  assign degrees = w_mag[RAW_WIDTH-1:FRAC_BITS];

  // sixteenths -> tenths, truncated: (frac * 10) / 16
  assign w_frac_x10 = {4'b0000, w_mag[FRAC_BITS-1:0]} * 8'd10;
  assign tenths     = 4'(w_frac_x10 >> 4);

endmodule : tmp101_code_to_decimal
`default_nettype wire

// File: rtl/tmp101_sample_collector.sv
`default_nettype none
// ============================================================================
// Module   : tmp101_sample_collector
// Brief    : Periodic TMP101 read sequencer; assembles and publishes readings.
// Revision : 1.0 - initial release
// ============================================================================
module tmp101_sample_collector
  import tmp101_pkg::*;
#(
  parameter int SamplePeriodCycles = 6000000,
  parameter int TimeoutCycles      = 120000,
  parameter int CounterWidth       = 24
) (
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 ByteReady,
  input  logic [7:0]           ReceivedData,
  output logic                 Go,
  output logic [RAW_WIDTH-1:0] RawTemp,
  output logic                 Sign,
  output logic [7:0]           Degrees,
  output logic [3:0]           Tenths,
  output logic                 TempValid,
  output logic                 Timeout
);

  localparam logic [CounterWidth-1:0] PERIOD_LAST  = CounterWidth'(SamplePeriodCycles - 1);
  localparam logic [CounterWidth-1:0] TIMEOUT_LAST = CounterWidth'(TimeoutCycles - 1);

  state_t                  r_state;
  logic [CounterWidth-1:0] r_count;
  logic [7:0]              r_msb;

  logic [RAW_WIDTH-1:0]    w_raw_next;
  logic                    w_sign;
  logic [7:0]              w_degrees;
  logic [3:0]              w_tenths;

  assign w_raw_next = {r_msb, ReceivedData[7:4]};

  tmp101_code_to_decimal u_code_to_decimal (
    .raw     (w_raw_next),
    .sign    (w_sign),
    .degrees (w_degrees),
    .tenths  (w_tenths)
  );

  // The counter is zero in the Go cycle and in the publish cycle, so both the
  // read window and the next period are measured from the visible strobe.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_WAIT;
      r_count   <= '0;
      r_msb     <= '0;
      Go        <= 1'b0;
      TempValid <= 1'b0;
      Timeout   <= 1'b0;
      RawTemp   <= '0;
      Sign      <= 1'b0;
      Degrees   <= '0;
      Tenths    <= '0;
    end else begin
      Go        <= 1'b0;
      TempValid <= 1'b0;
      Timeout   <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (!Enable) begin
            r_count <= '0;
          end else if (r_count == PERIOD_LAST) begin
            r_count <= '0;
            r_state <= ST_START;
            Go      <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_START: begin
          r_count <= r_count + 1'b1;
          r_state <= ST_MSB;
        end
        ST_MSB: begin
          if (ByteReady) begin
            r_msb   <= ReceivedData;
            r_count <= r_count + 1'b1;
            r_state <= ST_LSB;
          end else if (r_count == TIMEOUT_LAST) begin
            Timeout <= 1'b1;
            r_count <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_LSB: begin
          if (ByteReady) begin
            RawTemp   <= w_raw_next;
            Sign      <= w_sign;
            Degrees   <= w_degrees;
            Tenths    <= w_tenths;
            TempValid <= 1'b1;
            r_count   <= '0;
            r_state   <= ST_PUBLISH;
          end else if (r_count == TIMEOUT_LAST) begin
            Timeout <= 1'b1;
            r_count <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_PUBLISH: begin
          r_count <= CounterWidth'(Enable);
          r_state <= ST_WAIT;
        end
        default: begin
          r_count <= '0;
          r_state <= ST_WAIT;
        end
      endcase
    end
  end

endmodule : tmp101_sample_collector
`default_nettype wire

// File: tb/tb_tmp101_sample_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tmp101_sample_collector
// Brief    : Scoreboard bench for the TMP101 sample collector (short periods).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmp101_sample_collector;

  localparam int PERIOD = 100;
  localparam int TMO    = 50;

  typedef struct packed {
    logic [11:0] raw;
    logic        sign;
    logic [7:0]  deg;
    logic [3:0]  ten;
  } reading_t;

  logic        clock        = 1'b0;
  logic        Reset        = 1'b1;
  logic        Enable       = 1'b1;
  logic        ByteReady    = 1'b0;
  logic [7:0]  ReceivedData = 8'h00;
  logic        Go;
  logic [11:0] RawTemp;
  logic        Sign;
  logic [7:0]  Degrees;
  logic [3:0]  Tenths;
  logic        TempValid;
  logic        Timeout;

  int n_checks = 0;
  int n_fail   = 0;
  reading_t sb[$];

  always #5 clock = ~clock;

  tmp101_sample_collector #(
    .SamplePeriodCycles (PERIOD),
    .TimeoutCycles      (TMO),
    .CounterWidth       (24)
  ) dut (
    .clock        (clock),
    .Reset        (Reset),
    .Enable       (Enable),
    .ByteReady    (ByteReady),
    .ReceivedData (ReceivedData),
    .Go           (Go),
    .RawTemp      (RawTemp),
    .Sign         (Sign),
    .Degrees      (Degrees),
    .Tenths       (Tenths),
    .TempValid    (TempValid),
    .Timeout      (Timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until Go is seen; n = cycles taken (-1 if the bound expired).
  task automatic wait_go(input int limit, output int n, output int tv, output int to);
    n = 0; tv = 0; to = 0;
    do begin
      tick();
      n++;
      if (TempValid === 1'b1) tv++;
      if (Timeout === 1'b1) to++;
    end while (Go !== 1'b1 && n < limit);
    if (Go !== 1'b1) n = -1;
  endtask

  // Starts at the Go cycle; ends in the cycle TempValid must be high.
  task automatic read_bytes(input logic [7:0] msb, input logic [7:0] lsb,
                            input reading_t exp, input string tag);
    reading_t got, want;
    sb.push_back(exp);
    tick();
    n_checks++;
    if (Go !== 1'b0) begin
      n_fail++;
      $display("FAIL %s go_width: Go=%b required 0", tag, Go);
    end
    tick();
    ReceivedData = msb; ByteReady = 1'b1;
    tick();
    ByteReady = 1'b0; ReceivedData = 8'hA5;
    tick();
    tick();
    ReceivedData = lsb; ByteReady = 1'b1;
    tick();
    ByteReady = 1'b0;
    n_checks++;
    if (TempValid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid_latency: TempValid=%b required 1", tag, TempValid);
    end
    want = sb.pop_front();
    got  = {RawTemp, Sign, Degrees, Tenths};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s reading: raw=%h sign=%b deg=%0d ten=%0d required raw=%h sign=%b deg=%0d ten=%0d",
               tag, got.raw, got.sign, got.deg, got.ten, want.raw, want.sign, want.deg, want.ten);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({Go, TempValid, Timeout, RawTemp, Sign, Degrees, Tenths} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: go=%b tv=%b to=%b raw=%h sign=%b deg=%0d ten=%0d required all 0",
               Go, TempValid, Timeout, RawTemp, Sign, Degrees, Tenths);
    end
  endtask

  task automatic test_first_go();
    int n, tv, to;
    Reset = 1'b0;
    wait_go(3 * PERIOD, n, tv, to);
    n_checks++;
    if (n != PERIOD || tv != 0 || to != 0) begin
      n_fail++;
      $display("FAIL first_go: cycles=%0d tv=%0d to=%0d required %0d 0 0", n, tv, to, PERIOD);
    end
  endtask

  task automatic test_readings();
    logic [7:0] msbs[5];
    logic [7:0] lsbs[5];
    reading_t   exps[5];
    int n, tv, to;
    msbs = '{8'h19, 8'hE7, 8'hFF, 8'h00, 8'h19};
    lsbs = '{8'h80, 8'h00, 8'hF0, 8'hF0, 8'h8C};
    exps = '{ {12'h198, 1'b0, 8'd25, 4'd5},
              {12'hE70, 1'b1, 8'd25, 4'd0},
              {12'hFFF, 1'b1, 8'd0,  4'd0},
              {12'h00F, 1'b0, 8'd0,  4'd9},
              {12'h198, 1'b0, 8'd25, 4'd5} };
    for (int i = 0; i < 5; i++) begin
      read_bytes(msbs[i], lsbs[i], exps[i], $sformatf("read%0d", i));
      wait_go(3 * PERIOD, n, tv, to);
      n_checks++;
      if (n != PERIOD || tv != 0 || to != 0) begin
        n_fail++;
        $display("FAIL read%0d next_go: cycles=%0d tv=%0d to=%0d required %0d 0 0", i, n, tv, to, PERIOD);
      end
    end
  endtask

  task automatic test_timeout();
    int to_at, tv_seen, n, tv, to;
    reading_t got, want;
    to_at = -1; tv_seen = 0;
    want = {12'h198, 1'b0, 8'd25, 4'd5};
    for (int k = 1; k <= 4 * TMO && to_at < 0; k++) begin
      ByteReady = (k == 4); ReceivedData = 8'h42;
      tick();
      if (TempValid === 1'b1) tv_seen++;
      if (Timeout === 1'b1) to_at = k;
    end
    ByteReady = 1'b0;
    n_checks++;
    if (to_at != TMO || tv_seen != 0) begin
      n_fail++;
      $display("FAIL timeout_delay: at=%0d tv=%0d required %0d 0", to_at, tv_seen, TMO);
    end
    got = {RawTemp, Sign, Degrees, Tenths};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL timeout_hold: raw=%h deg=%0d ten=%0d required raw=%h deg=%0d ten=%0d",
               got.raw, got.deg, got.ten, want.raw, want.deg, want.ten);
    end
    wait_go(3 * PERIOD, n, tv, to);
    n_checks++;
    if (n != PERIOD || tv != 0 || to != 0) begin
      n_fail++;
      $display("FAIL timeout_next_go: cycles=%0d tv=%0d to=%0d required %0d 0 0", n, tv, to, PERIOD);
    end
  endtask

  // LSB arrives in exactly the terminal-count cycle: the byte must win.
  task automatic test_tie();
    int to_seen, n, tv, to;
    reading_t got, want;
    to_seen = 0;
    want = {12'h0A0, 1'b0, 8'd10, 4'd0};
    sb.push_back(want);
    for (int k = 1; k <= TMO; k++) begin
      ByteReady    = (k == 4 || k == TMO);
      ReceivedData = (k == 4) ? 8'h0A : 8'h0B;
      tick();
      if (Timeout === 1'b1) to_seen++;
    end
    ByteReady = 1'b0;
    n_checks++;
    if (TempValid !== 1'b1 || to_seen != 0) begin
      n_fail++;
      $display("FAIL tie_byte_wins: tv=%b timeouts=%0d required 1 0", TempValid, to_seen);
    end
    want = sb.pop_front();
    got  = {RawTemp, Sign, Degrees, Tenths};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL tie_reading: raw=%h deg=%0d ten=%0d required raw=%h deg=%0d ten=%0d",
               got.raw, got.deg, got.ten, want.raw, want.deg, want.ten);
    end
    wait_go(3 * PERIOD, n, tv, to);
    n_checks++;
    if (n != PERIOD || tv != 0 || to != 0) begin
      n_fail++;
      $display("FAIL tie_next_go: cycles=%0d tv=%0d to=%0d required %0d 0 0", n, tv, to, PERIOD);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, tv, to, go_cnt, tv_cnt, to_cnt;
    reading_t got, want;
    tick(); tick();
    ReceivedData = 8'hE7; ByteReady = 1'b1;
    tick();
    ByteReady = 1'b0;
    tick();
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({Go, TempValid, Timeout, RawTemp, Sign, Degrees, Tenths} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: go=%b tv=%b to=%b raw=%h deg=%0d ten=%0d required all 0",
               Go, TempValid, Timeout, RawTemp, Degrees, Tenths);
    end
    ReceivedData = 8'h55; ByteReady = 1'b1;
    go_cnt = 0; tv_cnt = 0; to_cnt = 0;
    repeat (3) begin
      tick();
      go_cnt += int'(Go); tv_cnt += int'(TempValid); to_cnt += int'(Timeout);
    end
    ByteReady = 1'b0;
    Reset = 1'b0;
    wait_go(3 * PERIOD, n, tv, to);
    n_checks++;
    if (go_cnt != 0 || tv_cnt != 0 || to_cnt != 0 || n != PERIOD || tv != 0 || to != 0) begin
      n_fail++;
      $display("FAIL reset_restart: strobes=%0d/%0d/%0d cycles=%0d tv=%0d to=%0d required 0/0/0 %0d 0 0",
               go_cnt, tv_cnt, to_cnt, n, tv, to, PERIOD);
    end
    Enable = 1'b0;
    read_bytes(8'hFF, 8'hF0, {12'hFFF, 1'b1, 8'd0, 4'd0}, "disable_mid_read");
    go_cnt = 0; tv_cnt = 0; to_cnt = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      ByteReady = (k % 7 == 3); ReceivedData = 8'h33;
      tick();
      go_cnt += int'(Go); tv_cnt += int'(TempValid); to_cnt += int'(Timeout);
    end
    ByteReady = 1'b0;
    n_checks++;
    if (go_cnt != 0 || tv_cnt != 0 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL disabled_idle: go=%0d tv=%0d to=%0d required 0 0 0", go_cnt, tv_cnt, to_cnt);
    end
    want = {12'hFFF, 1'b1, 8'd0, 4'd0};
    got  = {RawTemp, Sign, Degrees, Tenths};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL disabled_hold: raw=%h sign=%b required raw=%h sign=%b",
               got.raw, got.sign, want.raw, want.sign);
    end
  endtask

  initial begin
    test_reset();
    test_first_go();
    test_readings();
    test_timeout();
    test_tie();
    test_reset_mid_read();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tmp101_sample_collector
`default_nettype wire
